// File: rtl/uart_byte_rx_pkg.sv
// Shared UART definitions: frame size, default bit period and receiver FSM states.
package uart_byte_rx_pkg;

    localparam int UART_DATA_BITS        = 8;
    localparam int UART_CLKS_PER_BIT_DEF = 100;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_START = 3'd1,
        ST_DATA  = 3'd2,
        ST_STOP  = 3'd3,
        ST_BRK   = 3'd4
    } rx_state_e;

endpackage

// File: rtl/uart_byte_rx_sync.sv
// Two-flop synchronizer for a single asynchronous bit, with a configurable reset value.
module uart_byte_rx_sync #(
    parameter logic RESET_VAL = 1'b1
) (
    input  logic clk,
    input  logic rst,
    input  logic d_i,
    output logic q_o
);

    logic meta_d, meta_q;
    logic sync_d, sync_q;

    // Next value of each synchronizer stage
    always_comb begin
        meta_d = d_i;
        sync_d = meta_q;
    end

    // Synchronizer stages; reset to the line's idle level
    always_ff @(posedge clk) begin
        if (rst) begin
            meta_q <= RESET_VAL;
            sync_q <= RESET_VAL;
        end else begin
            meta_q <= meta_d;
            sync_q <= sync_d;
        end
    end

    assign q_o = sync_q;

endmodule

// File: rtl/uart_byte_rx.sv
// 8N1 UART receiver: start-bit validation, mid-bit sampling, stop-bit check and a
// one-entry valid/ready holding register with framing and overrun pulses.
module uart_byte_rx
    import uart_byte_rx_pkg::*;
#(
    parameter int CLKS_PER_BIT = UART_CLKS_PER_BIT_DEF
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      rx_i,
    output logic [UART_DATA_BITS-1:0] rx_data,
    output logic                      rx_valid,
    input  logic                      rx_ready,
    output logic                      rx_busy,
    output logic                      frame_err,
    output logic                      overrun
);

    localparam int                CNT_W     = $clog2(CLKS_PER_BIT);
    localparam logic [CNT_W-1:0]  HALF_LAST = CNT_W'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CNT_W-1:0]  FULL_LAST = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [2:0]        IDX_LAST  = 3'(UART_DATA_BITS - 1);

    logic                      rxs;
    rx_state_e                 state_d, state_q;
    logic [CNT_W-1:0]          cnt_d, cnt_q;
    logic [2:0]                idx_d, idx_q;
    logic [UART_DATA_BITS-1:0] shift_d, shift_q;
    logic                      rxs_prev_d, rxs_prev_q;
    logic                      deliver_d, deliver_q;
    logic [UART_DATA_BITS-1:0] data_d, data_q;
    logic                      valid_d, valid_q;
    logic                      ferr_d, ferr_q;
    logic                      ovr_d, ovr_q;

    uart_byte_rx_sync #(
        .RESET_VAL (1'b1)
    ) u_sync (
        .clk (clk),
        .rst (rst),
        .d_i (rx_i),
        .q_o (rxs)
    );

    // Frame FSM: start detect, mid-bit sampling and stop-bit decision
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        idx_d      = idx_q;
        shift_d    = shift_q;
        rxs_prev_d = rxs;
        deliver_d  = 1'b0;
        ferr_d     = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (rxs_prev_q && !rxs) begin
                    state_d = ST_START;
                    cnt_d   = '0;
                end
            end
            ST_START: begin
                if (cnt_q == HALF_LAST) begin
                    cnt_d = '0;
                    idx_d = '0;
                    // A line back high at mid start bit was only a glitch
                    state_d = rxs ? ST_IDLE : ST_DATA;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            ST_DATA: begin
                if (cnt_q == FULL_LAST) begin
                    cnt_d   = '0;
                    shift_d = {rxs, shift_q[UART_DATA_BITS-1:1]};
                    if (idx_q == IDX_LAST) begin
                        state_d = ST_STOP;
                    end else begin
                        idx_d = idx_q + 1'b1;
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            ST_STOP: begin
                if (cnt_q == FULL_LAST) begin
                    cnt_d = '0;
                    if (rxs) begin
                        deliver_d = 1'b1;
                        state_d   = ST_IDLE;
                    end else begin
                        ferr_d  = 1'b1;
                        state_d = ST_BRK;
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            ST_BRK: begin
                // Only a return to idle level re-arms start detection
                if (rxs) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Holding register: consumer handshake and load/overrun decision
    always_comb begin
        data_d  = data_q;
        valid_d = valid_q;
        ovr_d   = 1'b0;
        if (valid_q && rx_ready) begin
            valid_d = 1'b0;
        end
        if (deliver_q) begin
            // Space exists if empty or the current byte is leaving this cycle
            if (!valid_q || rx_ready) begin
                data_d  = shift_q;
                valid_d = 1'b1;
            end else begin
                ovr_d = 1'b1;
            end
        end
    end

    // Control and output registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            cnt_q      <= '0;
            idx_q      <= '0;
            rxs_prev_q <= 1'b1;
            deliver_q  <= 1'b0;
            data_q     <= '0;
            valid_q    <= 1'b0;
            ferr_q     <= 1'b0;
            ovr_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            idx_q      <= idx_d;
            rxs_prev_q <= rxs_prev_d;
            deliver_q  <= deliver_d;
            data_q     <= data_d;
            valid_q    <= valid_d;
            ferr_q     <= ferr_d;
            ovr_q      <= ovr_d;
        end
    end

    // Shift register holds only in-flight data, so it needs no reset
    always_ff @(posedge clk) begin
        shift_q <= shift_d;
    end

    assign rx_data   = data_q;
    assign rx_valid  = valid_q;
    assign rx_busy   = (state_q == ST_START) || (state_q == ST_DATA) || (state_q == ST_STOP);
    assign frame_err = ferr_q;
    assign overrun   = ovr_q;

endmodule
